hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Producer side of the EX-stage operand-forwarding interface: generates the
//  ForwardA/ForwardB select codes consumed by the EX operand muxes. Also drives
//  the load-use stall and bubble controls for the 5-stage pipeline.
//  Tracks the destination tags of the ID/EX, EX/MEM and MEM/WB stages in its own
//  shadow pipeline. Sits beside the ID/EX register; its outputs are registered
//  so they are valid during the EX cycle of the consuming instruction.
// PARAMETERS
//  REG_AW      5   register-index width
//  MULDIV_LAT  4   EX occupancy in cycles of a mul/div op (only with HFU_MULDIV_EN)
// PORTS
//  clk           in   1        pipeline clock
//  rst           in   1        async reset, active-high
//  id_valid      in   1        ID holds a real instruction
//  id_rs1        in   REG_AW   ID source 1 index
//  id_rs2        in   REG_AW   ID source 2 index
//  id_uses_rs1   in   1        instruction reads rs1
//  id_uses_rs2   in   1        instruction reads rs2
//  id_rd         in   REG_AW   ID destination index
//  id_reg_write  in   1        instruction writes rd
//  id_mem_read   in   1        instruction is a load
//  id_muldiv     in   1        mul/div op (ignored without HFU_MULDIV_EN)
//  ex_flush      in   1        taken branch/jump resolved in EX
//  ForwardA      out  2        EX src1 select: 00 regfile, 01 WB Write_data, 10 MEM rd_data
//  ForwardB      out  2        EX src2 select, same encoding
//  stall         out  1        hold PC and IF/ID register
//  bubble        out  1        load NOP into ID/EX this cycle
// BEHAVIOUR
//  - Reset (async, rst=1): all shadow tags invalid. ForwardA/B=00. stall=0, bubble=0. Muldiv counter=0.
//  - Shadow pipe: tag = {valid, rd, reg_write, mem_read}. Each posedge: MEM->WB and EX->MEM.
//    ID->EX uses the ID tag, or an invalid tag when bubble=1.
//  - A stage matches source s when valid & reg_write & rd!=0 & rd==s & uses_s.
//  - Combinational select per source (priority high->low):
//    match EX & !mem_read -> 10; match MEM -> 01; else 00.
//  - ForwardA/B registered: load at posedge when ID advances into EX.
//    They are 00 when a bubble enters EX. Code 11 is never produced.
//  - Load-use: id_valid & EX tag is a load matching either used source.
//    Result: stall=1, bubble=1 (combinational), exactly one cycle.
//    The next cycle the load is in MEM and the consumer re-evaluates to 01.
//  - ex_flush: bubble=1, stall=0. Flush overrides load-use stall.
//    The ID instruction is discarded and never forwarded to.
//  - Same rd in EX and MEM: the EX (younger) producer wins.
//  - rd==0 never forwards and never stalls.
//  - rst asserted mid-stall: stall/bubble deassert immediately; all tags cleared.
// CONFIGURATION
//  HFU_MULDIV_EN defined:
//   - id_muldiv entering EX loads the counter with MULDIV_LAT-1.
//   - While the counter is nonzero: stall=1, the EX tag is held, and MEM receives an
//     invalid tag. ForwardA/B are held.
//   - ex_flush clears the counter.
//  HFU_MULDIV_EN undefined: id_muldiv ignored, no counter logic.
// STRUCTURE
//  - Shared package pipe_pkg: FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the
//    stage-tag struct/width constants. The EX operand muxes use the same constants.
//  - One sub-module, fwd_select: pure combinational compare for one source, instanced
//    twice (rs1, rs2). Shadow pipe, stall logic and counter stay in the top.
// TESTING
//  1 EX-to-EX: add x5 then sub x6,x5,x1 back-to-back -> ForwardA=10 in sub's EX, no stall.
//  2 MEM-to-EX: add x5; nop; or x7,x2,x5 -> ForwardB=01, ForwardA=00.
//  3 Load-use: lw x8; add x9,x8,x8 -> stall=1 and bubble=1 for one cycle.
//    Then ForwardA=ForwardB=01 in add's EX.
//  4 Double producer: add x5; addi x5; sub x1,x5,x0 -> ForwardA=10 (younger wins).
//    Also addi x0 then use of x0 -> 00.
//  5 Flush during load-use: lw x8; add x9,x8 with ex_flush=1 -> stall=0, bubble=1.
//    Nothing is forwarded to x9.
//  6 HFU_MULDIV_EN, MULDIV_LAT=4: mul x3 -> stall=1 for 3 cycles, then dependent add sees 10.
//    rst pulse mid-sequence -> all outputs 0 same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - forwarding select codes, stage-tag type and tag compare helper
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_t;

    localparam int         TAG_W    = $bits(stage_tag_t);
    localparam stage_tag_t TAG_NONE = '0;

    // x0 is hardwired to zero, so a producer targeting it never matches.
    function automatic logic tag_match(input stage_tag_t t,
                                       input logic [REG_AW_DEF-1:0] src,
                                       input logic uses);
        return t.valid & t.reg_write & (t.rd != '0) & (t.rd == src) & uses;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding select and load-hit detect for one source operand
module fwd_select
    import pipe_pkg::*;
(
    input  stage_tag_t             ex_tag_i,
    input  stage_tag_t             mem_tag_i,
    input  logic [REG_AW_DEF-1:0]  src_i,
    input  logic                   uses_i,
    output logic [1:0]             sel_o,
    output logic                   load_hit_o
);

    logic ex_hit;
    logic mem_hit;
    logic unused_mem_ld;

    assign ex_hit        = tag_match(ex_tag_i, src_i, uses_i);
    assign mem_hit       = tag_match(mem_tag_i, src_i, uses_i);
    assign load_hit_o    = ex_hit & ex_tag_i.mem_read;
    assign unused_mem_ld = mem_tag_i.mem_read;

    // The younger EX producer wins over MEM; a load in EX cannot forward yet.
    always_comb begin
        sel_o = FWD_REGFILE;
        if (ex_hit && !ex_tag_i.mem_read) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding selects plus load-use/flush stall control
// Optional mul/div occupancy stall enabled by defining HFU_MULDIV_EN.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_muldiv,
    input  logic              ex_flush,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall,
    output logic              bubble
);

    stage_tag_t id_tag;
    stage_tag_t ex_q, mem_q, wb_q;
    logic [1:0] sel_a, sel_b;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       ld_a, ld_b, load_use;
    logic       muldiv_busy;
    logic       unused_wb;

    assign id_tag.valid     = id_valid;
    assign id_tag.rd        = id_rd;
    assign id_tag.reg_write = id_reg_write;
    assign id_tag.mem_read  = id_mem_read;

    fwd_select u_fwd_a (
        .ex_tag_i   (ex_q),
        .mem_tag_i  (mem_q),
        .src_i      (id_rs1),
        .uses_i     (id_valid & id_uses_rs1),
        .sel_o      (sel_a),
        .load_hit_o (ld_a)
    );

    fwd_select u_fwd_b (
        .ex_tag_i   (ex_q),
        .mem_tag_i  (mem_q),
        .src_i      (id_rs2),
        .uses_i     (id_valid & id_uses_rs2),
        .sel_o      (sel_b),
        .load_hit_o (ld_b)
    );

    assign load_use = ld_a | ld_b;
    // Gated by rst so stall/bubble drop in the same cycle reset is asserted.
    assign stall    = !rst & !ex_flush & (load_use | muldiv_busy);
    assign bubble   = !rst & (ex_flush | (load_use & !muldiv_busy));

`ifdef HFU_MULDIV_EN
    localparam int CNT_W = $clog2(MULDIV_LAT) + 1;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_md;

    assign muldiv_busy = (cnt_q != '0);
    assign unused_md   = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ex_flush) begin
            cnt_q <= '0;
        end else if (muldiv_busy) begin
            cnt_q <= cnt_q - 1'b1;
        end else if (!bubble && id_valid && id_muldiv) begin
            cnt_q <= CNT_W'(MULDIV_LAT - 1);
        end
    end
`else
    logic unused_md;

    assign muldiv_busy = 1'b0;
    assign unused_md   = id_muldiv ^ (MULDIV_LAT == 0);
`endif

    assign unused_wb = ^wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= TAG_NONE;
            mem_q   <= TAG_NONE;
            wb_q    <= TAG_NONE;
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else begin
            wb_q <= mem_q;
            // A busy mul/div keeps its EX slot and the selects of the op in EX.
            if (muldiv_busy && !ex_flush) begin
                mem_q <= TAG_NONE;
            end else begin
                mem_q   <= ex_q;
                ex_q    <= bubble ? TAG_NONE : id_tag;
                fwd_a_q <= bubble ? FWD_REGFILE : sel_a;
                fwd_b_q <= bubble ? FWD_REGFILE : sel_b;
            end
        end
    end

    assign ForwardA = fwd_a_q;
    assign ForwardB = fwd_b_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed-vector bench for hazard_forward_unit
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       id_reg_write, id_mem_read, id_muldiv;
    logic       ex_flush;
    logic [1:0] ForwardA, ForwardB;
    logic       stall, bubble;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_muldiv    (id_muldiv),
        .ex_flush     (ex_flush),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .stall        (stall),
        .bubble       (bubble)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one ID-stage instruction; rs fields with use flags, rd with write/load/muldiv flags.
    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic md, input logic fl);
        id_valid = v;  id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_muldiv = md; ex_flush = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            nop();
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        nop();
        #2;
        check("rst_fwda", ForwardA, 2'b00);
        check("rst_fwdb", ForwardB, 2'b00);
        check("rst_stall", stall, 1'b0);
        check("rst_bubble", bubble, 1'b0);
        step();
        rst = 1'b0;
        drain();

        // EX-to-EX: add x5,x1,x2 ; sub x6,x5,x1
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); step();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
        check("ex_ex_stall", stall, 1'b0);
        check("ex_ex_bubble", bubble, 1'b0);
        step();
        check("ex_ex_fwda", ForwardA, 2'b10);
        check("ex_ex_fwdb", ForwardB, 2'b00);
        drain();

        // MEM-to-EX: add x5 ; nop ; or x7,x2,x5
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); step();
        nop(); step();
        set_id(1, 5'd2, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0); step();
        check("mem_ex_fwda", ForwardA, 2'b00);
        check("mem_ex_fwdb", ForwardB, 2'b01);
        drain();

        // Load-use: lw x8 ; add x9,x8,x8
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0); step();
        set_id(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 0);
        check("lu_stall", stall, 1'b1);
        check("lu_bubble", bubble, 1'b1);
        step();
        check("lu_stall_once", stall, 1'b0);
        check("lu_bubble_once", bubble, 1'b0);
        check("lu_bubble_fwda", ForwardA, 2'b00);
        step();
        check("lu_fwda", ForwardA, 2'b01);
        check("lu_fwdb", ForwardB, 2'b01);
        drain();

        // Double producer: add x5 ; addi x5 ; sub x1,x5,x0
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); step();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0); step();
        set_id(1, 5'd5, 1, 5'd0, 1, 5'd1, 1, 0, 0, 0); step();
        check("dbl_fwda", ForwardA, 2'b10);
        check("dbl_fwdb", ForwardB, 2'b00);
        // addi x0 ; add x2,x0,x0
        set_id(1, 5'd3, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0); step();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0, 0, 0); step();
        check("x0_fwda", ForwardA, 2'b00);
        check("x0_fwdb", ForwardB, 2'b00);
        // lw x0 ; add using x0 never stalls
        set_id(1, 5'd3, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0); step();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0, 0, 0);
        check("x0_lu_stall", stall, 1'b0);
        step();
        drain();

        // Flush during load-use: lw x8 ; add x9,x8 with ex_flush
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0); step();
        set_id(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 1);
        check("fl_stall", stall, 1'b0);
        check("fl_bubble", bubble, 1'b1);
        step();
        set_id(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 0, 0);
        check("fl_post_stall", stall, 1'b0);
        step();
        check("fl_fwda", ForwardA, 2'b00);
        check("fl_fwdb", ForwardB, 2'b00);
        drain();

        // Reset mid-stall: add x5 ; lw x8,(x5) ; add x9,x8
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); step();
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0); step();
        check("pre_rst_fwda", ForwardA, 2'b10);
        set_id(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0);
        check("pre_rst_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_bubble", bubble, 1'b0);
        check("mid_rst_fwda", ForwardA, 2'b00);
        step();
        rst = 1'b0;
        step();
        check("post_rst_stall", stall, 1'b0);
        drain();

`ifdef HFU_MULDIV_EN
        // mul x3 ; add x4,x3,x0 -> three stall cycles then ForwardA=10
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, 0); step();
        set_id(1, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("md_stall", stall, 1'b1);
            check("md_bubble", bubble, 1'b0);
            step();
        end
        check("md_release", stall, 1'b0);
        step();
        check("md_fwda", ForwardA, 2'b10);
        drain();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, 0); step();
        set_id(1, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0, 0, 0);
        check("md2_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        check("md_rst_stall", stall, 1'b0);
        check("md_rst_fwda", ForwardA, 2'b00);
        step();
        rst = 1'b0;
        step();
        check("md_post_rst_stall", stall, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
